// File: rtl/traffic_light_controller_if.sv
// Signal bundle between the traffic light controller and the renderer.
// The controller side takes the emergency request and drives lights/debug.
interface traffic_light_controller_if;
  logic       emergency;
  logic       traffic0_color;
  logic       traffic1_color;
  logic       traffic2_color;
  logic       traffic3_color;
  logic       animateClk;
  logic [2:0] phase;

  modport master (
    input  emergency,
    output traffic0_color,
    output traffic1_color,
    output traffic2_color,
    output traffic3_color,
    output animateClk,
    output phase
  );

  modport slave (
    output emergency,
    input  traffic0_color,
    input  traffic1_color,
    input  traffic2_color,
    input  traffic3_color,
    input  animateClk,
    input  phase
  );
endinterface

// File: rtl/traffic_light_controller.sv
// Four-way intersection controller: EW/NS green phases with all-red
// clearance, emergency all-red override and a free-running animation clock.
module traffic_light_controller #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned GREEN_SECS = 8,
  parameter int unsigned CLEAR_SECS = 2,
  parameter int unsigned ANIM_DIV   = 250000
) (
  input logic dclk,
  input logic clr,
  traffic_light_controller_if.master bus
);

  typedef enum logic [2:0] {
    EW_GO = 3'd0,
    CLR_A = 3'd1,
    NS_GO = 3'd2,
    CLR_B = 3'd3,
    EMER  = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
  localparam logic [7:0]    GREEN_LAST = 8'(GREEN_SECS - 1);
  localparam logic [7:0]    CLEAR_LAST = 8'(CLEAR_SECS - 1);

  state_t          state_q;
  state_t          state_d;
  state_t          succ;
  logic [7:0]      sec_q;
  logic [7:0]      sec_d;
  logic [7:0]      last;
  logic [PW-1:0]   pre_q;
  logic            tick;
  logic            pre_hold;
  logic [AW-1:0]   anim_q;
  logic            anim_clk_q;

  assign tick     = (pre_q == PRE_LAST);
  assign pre_hold = bus.emergency || (state_q == EMER);
  assign last     = ((state_q == EW_GO) || (state_q == NS_GO))
                    ? GREEN_LAST : CLEAR_LAST;

  // One-second prescaler; held at zero around an emergency.
  always_ff @(posedge dclk) begin
    if (clr)
      pre_q <= '0;
    else if (pre_hold || tick)
      pre_q <= '0;
    else
      pre_q <= pre_q + 1'b1;
  end

  // Normal rotation order of the light sequence.
  always_comb begin
    succ = CLR_B;
    unique case (state_q)
      EW_GO:   succ = CLR_A;
      CLR_A:   succ = NS_GO;
      NS_GO:   succ = CLR_B;
      CLR_B:   succ = EW_GO;
      default: succ = CLR_B;
    endcase
  end

  // Next state and second counter; emergency outranks the tick.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    unique case (state_q)
      EMER: begin
        sec_d = '0;
        if (!bus.emergency)
          state_d = CLR_B;
      end
      EW_GO, CLR_A, NS_GO, CLR_B: begin
        if (bus.emergency) begin
          state_d = EMER;
          sec_d   = '0;
        end else if (tick) begin
          if (sec_q == last) begin
            state_d = succ;
            sec_d   = '0;
          end else begin
            sec_d = sec_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = CLR_B;
        sec_d   = '0;
      end
    endcase
  end

  // State and second counter registers.
  always_ff @(posedge dclk) begin
    if (clr) begin
      state_q <= CLR_B;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
    end
  end

  // Animation square wave, independent of the light sequence.
  always_ff @(posedge dclk) begin
    if (clr) begin
      anim_q     <= '0;
      anim_clk_q <= 1'b0;
    end else if (anim_q == ANIM_LAST) begin
      anim_q     <= '0;
      anim_clk_q <= ~anim_clk_q;
    end else begin
      anim_q <= anim_q + 1'b1;
    end
  end

  assign bus.traffic0_color = (state_q == EW_GO);
  assign bus.traffic1_color = (state_q == EW_GO);
  assign bus.traffic2_color = (state_q == NS_GO);
  assign bus.traffic3_color = (state_q == NS_GO);
  assign bus.animateClk     = anim_clk_q;
  assign bus.phase          = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with short timing parameters.
// Expected phases come from the interval lengths of the small configuration.
module tb_traffic_light_controller;

  logic dclk;
  logic clr;
  int   checks;
  int   errors;
  int   n_edges;

  traffic_light_controller_if bus ();

  traffic_light_controller #(
    .TICK_DIV   (4),
    .GREEN_SECS (3),
    .CLEAR_SECS (1),
    .ANIM_DIV   (2)
  ) dut (
    .dclk (dclk),
    .clr  (clr),
    .bus  (bus.master)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic c;
    c = clr;
    @(posedge dclk);
    #1;
    if (c)
      n_edges = 0;
    else
      n_edges++;
  endtask

  task automatic look(input string tag, input int ph);
    logic ew;
    logic ns;
    logic an;
    ew = (ph == 0);
    ns = (ph == 2);
    an = ((n_edges >> 1) & 1) != 0;
    chk({tag, "_phase"}, 32'(bus.phase), 32'(ph));
    chk({tag, "_t0"}, 32'(bus.traffic0_color), 32'(ew));
    chk({tag, "_t1"}, 32'(bus.traffic1_color), 32'(ew));
    chk({tag, "_t2"}, 32'(bus.traffic2_color), 32'(ns));
    chk({tag, "_t3"}, 32'(bus.traffic3_color), 32'(ns));
    chk({tag, "_anim"}, 32'(bus.animateClk), 32'(an));
    chk({tag, "_excl"},
        32'((bus.traffic0_color | bus.traffic1_color) &
            (bus.traffic2_color | bus.traffic3_color)),
        32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    n_edges       = 0;
    clr           = 1'b1;
    bus.emergency = 1'b0;

    step();
    step();
    look("rst", 3);

    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      look("rel", 3);
    end
    step();
    look("rel_ew", 0);

    for (int k = 1; k <= 32; k++) begin
      int ph;
      step();
      if (k < 12 || k == 32)
        ph = 0;
      else if (k < 16)
        ph = 1;
      else if (k < 28)
        ph = 2;
      else
        ph = 3;
      look("run", ph);
    end

    for (int k = 0; k < 20; k++)
      step();
    look("ns_mid", 2);
    bus.emergency = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      look("emer", 4);
    end
    bus.emergency = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      look("emer_clr", 3);
    end
    step();
    look("emer_ew", 0);

    for (int k = 0; k < 11; k++)
      step();
    look("ew_end", 0);
    bus.emergency = 1'b1;
    step();
    look("emer_tick", 4);
    bus.emergency = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      look("et_clr", 3);
    end
    step();
    look("et_ew", 0);

    for (int k = 0; k < 13; k++)
      step();
    look("clra_mid", 1);
    clr = 1'b1;
    step();
    look("clr_mid", 3);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      look("clr_rel", 3);
    end
    step();
    look("clr_ew", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: dclk cycles per one-second tick.
REQ-002 SHALL have parameter GREEN_SECS, default 8: green interval in ticks, legal range 1..255.
REQ-003 SHALL have parameter CLEAR_SECS, default 2: all-red clearance interval in ticks, legal range 1..255.
REQ-004 SHALL have parameter ANIM_DIV, default 250000: dclk cycles per animateClk half-period.
REQ-005 SHALL have port dclk  input  1  pixel clock, 25 MHz; single clock, all logic on rising edge.
REQ-006 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port emergency  input  1  level request to force all lights red; synchronous to dclk.
REQ-008 SHALL have ports traffic0_color (left), traffic1_color (right)  output  1 each  1 = green, 0 = red, east-west approaches.
REQ-009 SHALL have ports traffic2_color (top), traffic3_color (bottom)  output  1 each  1 = green, 0 = red, north-south approaches.
REQ-010 SHALL have port animateClk  output  1  free-running 50% square wave consumed by the renderer's animation step.
REQ-011 SHALL have port phase  output  3  current FSM state code, for debug.

Function
REQ-012 SHALL implement a prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick is high for the one cycle in which the count equals TICK_DIV-1.
REQ-013 SHALL implement an FSM with states EW_GO=0, CLR_A=1, NS_GO=2, CLR_B=3, EMER=4; codes 5-7 SHALL go to CLR_B on the next edge.
REQ-014 SHALL hold an 8-bit second counter sec_cnt that is cleared on every state change.
REQ-015 SHALL advance sequence EW_GO -> CLR_A -> NS_GO -> CLR_B -> EW_GO, with no other transitions when emergency is low.
REQ-016 SHALL, on a tick, transition if sec_cnt equals duration-1, else increment sec_cnt; duration is GREEN_SECS in EW_GO/NS_GO and CLEAR_SECS in CLR_A/CLR_B.
REQ-017 SHALL leave state and sec_cnt unchanged on non-tick cycles.
REQ-018 SHALL decode outputs Moore-style from the state register with zero added latency: traffic0/1 = (state==EW_GO), traffic2/3 = (state==NS_GO).
REQ-019 SHALL never drive an EW light and an NS light green in the same cycle.
REQ-020 SHALL, when emergency is high at a rising edge in any non-EMER state, enter EMER on that edge and clear sec_cnt and the prescaler; emergency has priority over tick.
REQ-021 SHALL remain in EMER with all outputs red while emergency is high; prescaler and sec_cnt SHALL be held at 0.
REQ-022 SHALL, at the first edge with emergency low while in EMER, go to CLR_B with sec_cnt=0 and prescaler=0, so that a full CLEAR_SECS clearance precedes EW_GO.
REQ-023 SHALL generate animateClk from a counter 0..ANIM_DIV-1, toggling animateClk on the edge where the counter equals ANIM_DIV-1; the counter is independent of FSM and emergency.
REQ-024 SHALL size counters to hold their maximum parameter value without overflow; no arithmetic wrap other than the specified wraps.

Reset
REQ-025 SHALL, on any edge with clr high, set state=CLR_B, sec_cnt=0, prescaler=0, animation counter=0, animateClk=0; all traffic outputs therefore read 0 and phase reads 3.
REQ-026 SHALL give clr priority over emergency and tick; clr asserted mid-interval SHALL abort the interval with no residual count.

Verification (TICK_DIV=4, GREEN_SECS=3, CLEAR_SECS=1, ANIM_DIV=2)
REQ-027 Release clr -> phase=3, all colors 0 for 3 edges; after the 4th edge, phase=0 and traffic0/1=1.
REQ-028 Free run from EW_GO entry -> EW green for 12 edges, CLR_A for 4, NS green (traffic2/3=1) for 12, CLR_B for 4; period 32 edges; EW and NS are never green together.
REQ-029 Assert emergency for 5 cycles mid-NS_GO -> next edge phase=4 with all colors 0; after release, phase=3 for 4 edges, then EW_GO.
REQ-030 Emergency and tick in the same cycle at the end of EW_GO -> phase=4, not 1.
REQ-031 After clr, animateClk toggles every 2 edges (period 4) and is unaffected by emergency pulses.
REQ-032 Assert clr for 1 cycle mid-CLR_A -> phase=3 with counters 0; EW_GO is re-entered 4 edges after release.
